dac_spi_tx: RTL and testbench
=============================

DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 SHALL have parameter cant_bits, default 16: width of the signed input sample.
REQ-002 SHALL have parameter CLK_DIV, default 4: sclk half-period in clk cycles, legal range >= 2.
REQ-003 SHALL have parameter GAP, default 8: minimum clk cycles cs stays high between frames, legal range >= 1.
REQ-004 SHALL have port clk  input  1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port dato_in  input  cant_bits: signed sample to convert, two's complement.
REQ-007 SHALL have port start  input  1: request to send dato_in; sampled only while ready=1.
REQ-008 SHALL have port ready  output  1: high when a new start will be accepted.
REQ-009 SHALL have port done  output  1: one-cycle pulse when a frame completes.
REQ-010 SHALL have port cs  output  1: DAC frame select (SYNC), active low.
REQ-011 SHALL have port sclk  output  1: serial clock, idle high.
REQ-012 SHALL have port sdata  output  1: serial data to DAC, MSB first.

Function
REQ-013 SHALL accept a request in a cycle where start=1 and ready=1 (cycle T0), latch dato_in at T0, and drop ready at T1.
REQ-014 SHALL ignore start while ready=0; no queuing, no change to the frame in flight.
REQ-015 SHALL saturate the latched sample to the 12-bit signed range: >2047 gives 2047, <-2048 gives -2048, otherwise the value is kept.
REQ-016 SHALL form the 12-bit code as the saturated value with bit 11 inverted (offset binary: -2048 -> 0x000, 0 -> 0x800, 2047 -> 0xFFF).
REQ-017 SHALL form a 16-bit frame word: bits 15:14 = 00 (don't care), bits 13:12 = 00 (normal mode), bits 11:0 = code.
REQ-018 SHALL use FSM states IDLE -> SETUP -> SHIFT -> GAP -> IDLE; ready=1 only in IDLE.
REQ-019 SHALL, at T1 (SETUP entry), drive cs=0, sclk=1 and sdata=frame bit 15, and hold them for CLK_DIV cycles.
REQ-020 SHALL, in SHIFT, send 16 bits: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; sdata updates to the next bit only on a sclk rising transition.
REQ-021 SHALL keep sdata stable across every sclk falling edge (the DAC samples on the falling edge).
REQ-022 SHALL keep cs low for exactly 33*CLK_DIV cycles (132 at default), then drive cs=1, sclk=1 and sdata=0.
REQ-023 SHALL assert done for exactly the one cycle in which cs returns high.
REQ-024 SHALL hold the GAP state for GAP cycles after cs rises, then assert ready.
REQ-025 SHALL use a 5-bit bit counter (16 down to 0) and a ceil(log2(CLK_DIV))-bit divider counter; neither counter wraps inside a frame.
REQ-026 SHALL accept a start asserted in the first IDLE cycle after GAP (back-to-back frames), giving a cs-high time of exactly GAP+1 cycles.

Reset
REQ-027 SHALL, while rst=0, immediately and asynchronously force: state IDLE, cs=1, sclk=1, sdata=0, done=0, ready=1, and all counters and the shift register to 0.
REQ-028 SHALL, when reset is asserted mid-frame, abort the frame with no done pulse and resume in IDLE after rst returns high.

Structure
REQ-029 SHALL place FSM state encodings, the frame width (16), the code width (12) and the control-bit constants in the shared package dac_pkg.
REQ-030 SHALL implement saturation and offset conversion in the sub-module dac_code_conv (combinational, cant_bits in, 12 bits out); the FSM, counters and shift register stay in dac_spi_tx.

Verification
REQ-031 SHALL cover: dato_in=0, start pulse -> 16 bits shifted = 0x0800; cs low 132 cycles; done once; ready again GAP cycles later.
REQ-032 SHALL cover: dato_in=1000 -> frame 0x0BE8; dato_in=-1 -> frame 0x07FF.
REQ-033 SHALL cover: dato_in=32767 -> frame 0x0FFF; dato_in=-32768 -> frame 0x0000 (saturation).
REQ-034 SHALL cover: start held high through a whole frame with dato_in changed mid-frame -> the frame in flight is unchanged and the next frame starts at the first IDLE cycle.
REQ-035 SHALL cover: rst=0 at SHIFT bit 7 -> cs=1, sclk=1 in the same cycle, no done pulse, ready=1; a new frame after release is correct.
REQ-036 SHALL cover, with a sampling checker: for every frame, sdata is unchanged from CLK_DIV-1 cycles before through the sclk falling edge.

Source files
------------

// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared constants, FSM encoding and frame builder for the DAC SPI transmitter
package dac_pkg;

    localparam int FRAME_W = 16;
    localparam int CODE_W  = 12;

    localparam logic [1:0] CTRL_DONT_CARE  = 2'b00;
    localparam logic [1:0] CTRL_MODE_NORMAL = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } state_t;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [CODE_W-1:0] code);
        return {CTRL_DONT_CARE, CTRL_MODE_NORMAL, code};
    endfunction

endpackage

// File: rtl/dac_code_conv.sv
// rtl/dac_code_conv.sv - saturate a signed sample to 12 bits and convert it to offset binary
module dac_code_conv
    import dac_pkg::*;
#(
    parameter int cant_bits = 16
) (
    input  logic signed [cant_bits-1:0] dato,
    output logic        [CODE_W-1:0]    code
);

    // Work at a width that holds both the input and the 12-bit limits.
    localparam int EXT_W = (cant_bits > CODE_W) ? cant_bits : CODE_W;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(2047);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-2048);

    logic signed [EXT_W-1:0]  ext;
    logic signed [CODE_W-1:0] sat;

    always_comb begin
        ext = EXT_W'(dato);
        if (ext > SAT_MAX) begin
            sat = 12'sh7FF;
        end else if (ext < SAT_MIN) begin
            sat = 12'sh800;
        end else begin
            sat = ext[CODE_W-1:0];
        end
        code = {~sat[CODE_W-1], sat[CODE_W-2:0]};
    end

endmodule

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - serialises one saturated 12-bit DAC code per start request onto a SYNC/SCLK/DIN link
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int cant_bits = 16,
    parameter int CLK_DIV   = 4,
    parameter int GAP       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [cant_bits-1:0] dato_in,
    input  logic                        start,
    output logic                        ready,
    output logic                        done,
    output logic                        cs,
    output logic                        sclk,
    output logic                        sdata
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    state_t               state, state_nx;
    logic [DIV_W-1:0]     div_cnt, div_cnt_nx;
    logic [4:0]           bit_cnt, bit_cnt_nx;
    logic [GAP_W-1:0]     gap_cnt, gap_cnt_nx;
    logic [FRAME_W-1:0]   shreg, shreg_nx;
    logic                 cs_nx, sclk_nx, sdata_nx, done_nx;
    logic [CODE_W-1:0]    code;
    logic [FRAME_W-1:0]   frame;
    logic                 div_end;

    dac_code_conv #(.cant_bits(cant_bits)) u_conv (
        .dato (dato_in),
        .code (code)
    );

    assign frame   = make_frame(code);
    assign ready   = (state == ST_IDLE);
    assign div_end = (div_cnt == DIV_LAST);

    always_comb begin
        state_nx   = state;
        div_cnt_nx = div_cnt;
        bit_cnt_nx = bit_cnt;
        gap_cnt_nx = gap_cnt;
        shreg_nx   = shreg;
        cs_nx      = cs;
        sclk_nx    = sclk;
        sdata_nx   = sdata;
        done_nx    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx   = ST_SETUP;
                    shreg_nx   = frame;
                    cs_nx      = 1'b0;
                    sclk_nx    = 1'b1;
                    sdata_nx   = frame[FRAME_W-1];
                    div_cnt_nx = '0;
                    bit_cnt_nx = 5'd16;
                end
            end
            ST_SETUP: begin
                if (div_end) begin
                    state_nx   = ST_SHIFT;
                    sclk_nx    = 1'b0;
                    div_cnt_nx = '0;
                end else begin
                    div_cnt_nx = div_cnt + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!div_end) begin
                    div_cnt_nx = div_cnt + 1'b1;
                end else begin
                    div_cnt_nx = '0;
                    if (!sclk) begin
                        // Data only moves on the rising edge so it is settled at the next fall.
                        sclk_nx    = 1'b1;
                        shreg_nx   = {shreg[FRAME_W-2:0], 1'b0};
                        sdata_nx   = shreg[FRAME_W-2];
                        bit_cnt_nx = bit_cnt - 1'b1;
                    end else if (bit_cnt == 5'd0) begin
                        state_nx   = ST_GAP;
                        cs_nx      = 1'b1;
                        sclk_nx    = 1'b1;
                        sdata_nx   = 1'b0;
                        done_nx    = 1'b1;
                        gap_cnt_nx = '0;
                    end else begin
                        sclk_nx = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx   = ST_IDLE;
                    gap_cnt_nx = '0;
                end else begin
                    gap_cnt_nx = gap_cnt + 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            cs      <= 1'b1;
            sclk    <= 1'b1;
            sdata   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_cnt_nx;
            bit_cnt <= bit_cnt_nx;
            gap_cnt <= gap_cnt_nx;
            shreg   <= shreg_nx;
            cs      <= cs_nx;
            sclk    <= sclk_nx;
            sdata   <= sdata_nx;
            done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - scoreboard bench for dac_spi_tx: frame content, timing, saturation, back-to-back and reset abort
module tb_dac_spi_tx;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] dato_in = '0;
    logic               ready, done, cs, sclk, sdata;

    dac_spi_tx #(.cant_bits(16), .CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .dato_in (dato_in),
        .start   (start),
        .ready   (ready),
        .done    (done),
        .cs      (cs),
        .sclk    (sclk),
        .sdata   (sdata)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    int          n_expected_done = 0;
    int          done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] model_frame(input int v);
        int s;
        s = (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
        return 16'(s + 2048);
    endfunction

    // Link monitor, sampled on the falling clk edge.
    logic [15:0] cap = '0;
    int          nbits = 0;
    int          low_len = 0;
    int          high_len = 0;
    int          last_high_len = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;
    logic        hist[CLK_DIV-1];
    logic        stable;

    initial for (int i = 0; i < CLK_DIV - 1; i++) hist[i] = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            nbits     = 0;
            low_len   = 0;
            high_len  = 0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b1;
            if (done) check("done_in_reset", done, 0);
        end else begin
            if (prev_cs && !cs) begin
                cap           = '0;
                nbits         = 0;
                low_len       = 0;
                last_high_len = high_len;
            end
            if (!cs) low_len++;
            if (!cs && prev_sclk && !sclk) begin
                stable = 1'b1;
                for (int i = 0; i < CLK_DIV - 1; i++) if (hist[i] !== sdata) stable = 1'b0;
                check("sdata_stable_at_fall", stable, 1);
                cap = {cap[14:0], sdata};
                nbits++;
            end
            if (!prev_cs && cs) begin
                check("done_at_cs_rise", done, 1);
                check("bit_count", nbits, 16);
                check("cs_low_len", low_len, 33 * CLK_DIV);
                if (exp_q.size() == 0) check("scoreboard_underflow", 1, 0);
                else check("frame", cap, exp_q.pop_front());
                if (done) done_cnt++;
                high_len = 0;
            end else if (done) begin
                check("done_stray", done, 0);
            end
            if (cs) high_len++;
            for (int i = CLK_DIV - 2; i > 0; i--) hist[i] = hist[i-1];
            hist[0]   = sdata;
            prev_cs   = cs;
            prev_sclk = sclk;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 2000) begin
            tick();
            n++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_done_then_ready(input string tag);
        int n = 0;
        while (!done && n < 2000) begin
            tick();
            n++;
        end
        if (!done) begin
            check({tag, "_done_timeout"}, 0, 1);
        end else begin
            n = 0;
            while (!ready && n < 100) begin
                tick();
                n++;
            end
            check({tag, "_gap_to_ready"}, n, GAP);
        end
    endtask

    task automatic send(input int v);
        wait_ready();
        dato_in = 16'(v);
        start   = 1'b1;
        exp_q.push_back(model_frame(v));
        tick();
        check("ready_drop", ready, 0);
        check("cs_low_at_t1", cs, 0);
        start = 1'b0;
        n_expected_done++;
        wait_done_then_ready("single");
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 1);
        check("rst_sdata", sdata, 0);
        check("rst_done", done, 0);
        check("rst_ready", ready, 1);
        rst = 1'b1;
        tick();

        send(0);
        send(1000);
        send(-1);
        send(32767);
        send(-32768);
        send(2047);
        send(-2048);
        send(2048);

        // Start held through a frame; dato_in changes mid-frame.
        wait_ready();
        dato_in = 16'sd500;
        start   = 1'b1;
        exp_q.push_back(model_frame(500));
        tick();
        repeat (40) tick();
        dato_in = -16'sd700;
        exp_q.push_back(model_frame(-700));
        n = 0;
        while (!ready && n < 2000) begin
            tick();
            n++;
        end
        check("b2b_ready_seen", ready, 1);
        tick();
        check("b2b_accept", ready, 0);
        start = 1'b0;
        tick();
        check("b2b_cs_high_len", last_high_len, GAP + 1);
        n_expected_done += 2;
        wait_done_then_ready("b2b");

        // Reset while bit 7 is on the wire.
        wait_ready();
        dato_in = 16'sd1234;
        start   = 1'b1;
        exp_q.push_back(model_frame(1234));
        tick();
        start = 1'b0;
        n = 0;
        while (nbits < 8 && n < 2000) begin
            tick();
            n++;
        end
        check("abort_reached_bit7", (nbits >= 8), 1);
        check("abort_cs_low_before", cs, 0);
        rst = 1'b0;
        #1;
        check("abort_cs", cs, 1);
        check("abort_sclk", sclk, 1);
        check("abort_sdata", sdata, 0);
        check("abort_done", done, 0);
        check("abort_ready", ready, 1);
        void'(exp_q.pop_back());
        repeat (3) tick();
        rst = 1'b1;
        tick();
        send(-5);

        repeat (20) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        check("done_count", done_cnt, n_expected_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
